axis_video_pattern_gen: RTL and testbench

AXI4-Stream video source that emits synthetic frames with the same framing as the passthrough monitor expects: tuser[0] on the first pixel of a frame and tlast on the last pixel of each line. It sits upstream of the passthrough monitor in bring-up and regression builds, so the monitor's col/line/fps readings can be checked against known values. Frame geometry, pattern and frame rate come from static configuration ports. Each frame's geometry and pattern are latched at the frame's start.

---
 rtl/axis_video_pattern_gen_if.sv | 14 +
 rtl/axis_video_pattern_gen.sv | 210 +++++++++++++++++++++
 tb/tb_axis_video_pattern_gen.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus carrying the pattern generator's pixels to its sink.
interface axis_video_pattern_gen_if #(
    parameter int WIDTH       = 48,
    parameter int TUSER_WIDTH = 1
);
    logic                   tvalid;
    logic                   tready;
    logic [WIDTH-1:0]       tdata;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_video_pattern_gen.sv
// Paced AXI4-Stream synthetic video source (x/y ramp, checker, frame-id patterns).
// Optional horizontal blanking between lines is enabled by defining AXIS_PATGEN_HBLANK_EN.
module axis_video_pattern_gen #(
    parameter int WIDTH       = 48,
    parameter int TUSER_WIDTH = 1,
    parameter int FREQ_HZ     = 100000000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic [7:0]  cfg_fps,
    input  logic [1:0]  cfg_pattern,
`ifdef AXIS_PATGEN_HBLANK_EN
    input  logic [15:0] cfg_hblank,
`endif
    axis_video_pattern_gen_if.master m_axis,
    output logic [31:0] frame_cnt,
    output logic [15:0] overrun_cnt,
    output logic        busy
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_DONE = 2'd2} state_t;

    localparam int PW = (WIDTH > 32) ? WIDTH : 32;

    function automatic logic [WIDTH-1:0] pixel_f(input logic [1:0] pat, input logic [15:0] px,
                                                 input logic [15:0] py, input logic [31:0] fid);
        logic [PW-1:0] wide;
        begin
            wide = {PW{1'b0}};
            case (pat)
                2'd0:    wide = PW'(px);
                2'd1:    wide = PW'(py);
                2'd2:    wide = {PW{px[3] ^ py[3]}};
                2'd3:    wide = PW'(fid);
                default: wide = {PW{1'b0}};
            endcase
            return wide[WIDTH-1:0];
        end
    endfunction

    state_t                 state_r;
    logic [31:0]            acc_r;
    logic                   pending_r;
    logic [15:0]            overrun_r;
    logic [15:0]            w_r, h_r, x_r, y_r;
    logic [1:0]             pat_r;
    logic [31:0]            fid_r, frame_cnt_r;
    logic                   tvalid_r, tlast_r, busy_r;
    logic [WIDTH-1:0]       tdata_r;
    logic [TUSER_WIDTH-1:0] tuser_r;

    logic [32:0] sum_s;
    logic        tick_s, start_s, hs_s, last_x_s, last_beat_s, start_gap_s, in_gap_s;
    logic [15:0] nx_s, ny_s, bx_s, by_s;

    assign sum_s       = {1'b0, acc_r} + {25'd0, cfg_fps};
    assign tick_s      = (cfg_fps != 8'd0) && (sum_s >= 33'(FREQ_HZ));
    assign start_s     = (state_r == ST_IDLE) && enable && (pending_r || (cfg_fps == 8'd0));
    assign hs_s        = tvalid_r && m_axis.tready;
    assign last_x_s    = (x_r == w_r - 16'd1);
    assign last_beat_s = last_x_s && (y_r == h_r - 16'd1);

    // Next raster position, and which position the output register loads from
    always_comb begin
        nx_s = x_r + 16'd1;
        ny_s = y_r;
        bx_s = x_r;
        by_s = y_r;
        if (last_x_s) begin
            nx_s = 16'd0;
            ny_s = y_r + 16'd1;
        end else begin
            nx_s = x_r + 16'd1;
            ny_s = y_r;
        end
        if (tvalid_r) begin
            bx_s = nx_s;
            by_s = ny_s;
        end else begin
            bx_s = x_r;
            by_s = y_r;
        end
    end

`ifdef AXIS_PATGEN_HBLANK_EN
    logic [15:0] hblank_r, blank_cnt_r;
    assign start_gap_s = last_x_s && (hblank_r != 16'd0);
    assign in_gap_s    = (blank_cnt_r != 16'd0);

    // Horizontal blanking: counter holds remaining idle cycles minus the one the reload takes
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hblank_r    <= 16'd0;
            blank_cnt_r <= 16'd0;
        end else if (start_s) begin
            hblank_r    <= cfg_hblank;
            blank_cnt_r <= 16'd0;
        end else if ((state_r == ST_ACTIVE) && hs_s && !last_beat_s && start_gap_s) begin
            blank_cnt_r <= hblank_r - 16'd1;
        end else if ((state_r == ST_ACTIVE) && !tvalid_r && in_gap_s) begin
            blank_cnt_r <= blank_cnt_r - 16'd1;
        end
    end
`else
    assign start_gap_s = 1'b0;
    assign in_gap_s    = 1'b0;
`endif

    // Frame-rate pacing accumulator, pending-tick flag and overrun counter
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_r     <= 32'd0;
            pending_r <= 1'b0;
            overrun_r <= 16'd0;
        end else begin
            if (cfg_fps == 8'd0)
                acc_r <= 32'd0;
            else if (tick_s)
                acc_r <= 32'(sum_s - 33'(FREQ_HZ));
            else
                acc_r <= sum_s[31:0];
            // A tick on the frame-start edge becomes the next pending tick, not an overrun
            if (start_s)
                pending_r <= tick_s;
            else if (tick_s && pending_r && (overrun_r != 16'hFFFF))
                overrun_r <= overrun_r + 16'd1;
            else if (tick_s)
                pending_r <= 1'b1;
        end
    end

    // Frame state machine with registered stream outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            tvalid_r    <= 1'b0;
            tdata_r     <= {WIDTH{1'b0}};
            tlast_r     <= 1'b0;
            tuser_r     <= {TUSER_WIDTH{1'b0}};
            frame_cnt_r <= 32'd0;
            x_r         <= 16'd0;
            y_r         <= 16'd0;
            w_r         <= 16'd1;
            h_r         <= 16'd1;
            pat_r       <= 2'd0;
            fid_r       <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_ACTIVE;
                        busy_r  <= 1'b1;
                        w_r     <= (cfg_width == 16'd0) ? 16'd1 : cfg_width;
                        h_r     <= (cfg_height == 16'd0) ? 16'd1 : cfg_height;
                        pat_r   <= cfg_pattern;
                        fid_r   <= frame_cnt_r;
                        x_r     <= 16'd0;
                        y_r     <= 16'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (hs_s && last_beat_s) begin
                        tvalid_r <= 1'b0;
                        tlast_r  <= 1'b0;
                        tuser_r  <= {TUSER_WIDTH{1'b0}};
                        state_r  <= ST_DONE;
                    end else if (tvalid_r && !m_axis.tready) begin
                        tvalid_r <= 1'b1;
                    end else if (hs_s && start_gap_s) begin
                        tvalid_r <= 1'b0;
                        tlast_r  <= 1'b0;
                        tuser_r  <= {TUSER_WIDTH{1'b0}};
                        x_r      <= nx_s;
                        y_r      <= ny_s;
                    end else if (!tvalid_r && in_gap_s) begin
                        tvalid_r <= 1'b0;
                    end else begin
                        tvalid_r <= 1'b1;
                        tdata_r  <= pixel_f(pat_r, bx_s, by_s, fid_r);
                        tlast_r  <= (bx_s == w_r - 16'd1);
                        tuser_r  <= TUSER_WIDTH'((bx_s == 16'd0) && (by_s == 16'd0));
                        x_r      <= bx_s;
                        y_r      <= by_s;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    frame_cnt_r <= frame_cnt_r + 32'd1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    tvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tdata  = tdata_r;
    assign m_axis.tlast  = tlast_r;
    assign m_axis.tuser  = tuser_r;
    assign frame_cnt     = frame_cnt_r;
    assign overrun_cnt   = overrun_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench for axis_video_pattern_gen: dut_a paces at FREQ_HZ=1000, dut_b at FREQ_HZ=100.
module tb_axis_video_pattern_gen;
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        rst_a, rst_b, en_a, en_b, rdy_a, rdy_b;
    logic [15:0] cfg_width, cfg_height;
    logic [7:0]  cfg_fps;
    logic [1:0]  cfg_pattern;
`ifdef AXIS_PATGEN_HBLANK_EN
    logic [15:0] cfg_hblank;
`endif
    logic [31:0] fc_a, fc_b;
    logic [15:0] ov_a, ov_b;
    logic        busy_a, busy_b;
    int tests = 0;
    int fails = 0;

    axis_video_pattern_gen_if #(.WIDTH(48), .TUSER_WIDTH(1)) ax_a ();
    axis_video_pattern_gen_if #(.WIDTH(48), .TUSER_WIDTH(1)) ax_b ();
    assign ax_a.tready = rdy_a;
    assign ax_b.tready = rdy_b;

    axis_video_pattern_gen #(.WIDTH(48), .TUSER_WIDTH(1), .FREQ_HZ(1000)) dut_a (
        .aclk(aclk), .aresetn(rst_a), .enable(en_a), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_fps(cfg_fps), .cfg_pattern(cfg_pattern),
`ifdef AXIS_PATGEN_HBLANK_EN
        .cfg_hblank(cfg_hblank),
`endif
        .m_axis(ax_a), .frame_cnt(fc_a), .overrun_cnt(ov_a), .busy(busy_a));

    axis_video_pattern_gen #(.WIDTH(48), .TUSER_WIDTH(1), .FREQ_HZ(100)) dut_b (
        .aclk(aclk), .aresetn(rst_b), .enable(en_b), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_fps(cfg_fps), .cfg_pattern(cfg_pattern),
`ifdef AXIS_PATGEN_HBLANK_EN
        .cfg_hblank(cfg_hblank),
`endif
        .m_axis(ax_b), .frame_cnt(fc_b), .overrun_cnt(ov_b), .busy(busy_b));

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        cfg_width = 16'd4; cfg_height = 16'd3; cfg_fps = 8'd0; cfg_pattern = 2'd0;
`ifdef AXIS_PATGEN_HBLANK_EN
        cfg_hblank = 16'd0;
`endif
        repeat (3) @(negedge aclk);
        tests++; if (ax_a.tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", ax_a.tvalid); end
        tests++; if (ax_a.tdata !== 48'd0) begin fails++; $display("FAIL reset_tdata: got %h expected 0", ax_a.tdata); end
        tests++; if (ax_a.tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b expected 0", ax_a.tlast); end
        tests++; if (ax_a.tuser !== 1'b0) begin fails++; $display("FAIL reset_tuser: got %b expected 0", ax_a.tuser); end
        tests++; if (fc_a !== 32'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d expected 0", fc_a); end
        tests++; if (ov_a !== 16'd0) begin fails++; $display("FAIL reset_overrun: got %0d expected 0", ov_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        tests++; if (ax_b.tvalid !== 1'b0 || fc_b !== 32'd0) begin fails++; $display("FAIL reset_b: got tvalid %b fc %0d expected 0 0", ax_b.tvalid, fc_b); end
    endtask

    task automatic test_basic_frame();
        int beat, cyc, first_cyc, last_cyc, vcnt;
        cfg_width = 16'd4; cfg_height = 16'd3; cfg_fps = 8'd0; cfg_pattern = 2'd0;
        rdy_a = 1'b1; en_a = 1'b1; rst_a = 1'b1;
        beat = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
        while (beat < 12 && cyc < 100) begin
            @(negedge aclk); cyc++;
            if (ax_a.tvalid === 1'b1) begin
                tests++; if (ax_a.tdata !== 48'(beat % 4)) begin fails++; $display("FAIL basic_tdata beat %0d: got %0h expected %0h", beat, ax_a.tdata, beat % 4); end
                tests++; if (ax_a.tlast !== ((beat % 4) == 3)) begin fails++; $display("FAIL basic_tlast beat %0d: got %b", beat, ax_a.tlast); end
                tests++; if (ax_a.tuser !== (beat == 0)) begin fails++; $display("FAIL basic_tuser beat %0d: got %b", beat, ax_a.tuser); end
                if (beat == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat++;
            end
        end
        tests++; if (beat != 12) begin fails++; $display("FAIL basic_beats: got %0d expected 12", beat); end
        tests++; if (first_cyc != 2) begin fails++; $display("FAIL basic_latency: got %0d expected 2", first_cyc); end
        tests++; if (last_cyc - first_cyc != 11) begin fails++; $display("FAIL basic_contiguous: got %0d expected 11", last_cyc - first_cyc); end
        cfg_pattern = 2'd3;
        @(negedge aclk);
        tests++; if (ax_a.tvalid !== 1'b0 || busy_a !== 1'b1 || fc_a !== 32'd0) begin fails++; $display("FAIL basic_done: got tvalid %b busy %b fc %0d expected 0 1 0", ax_a.tvalid, busy_a, fc_a); end
        @(negedge aclk);
        tests++; if (fc_a !== 32'd1 || busy_a !== 1'b0) begin fails++; $display("FAIL basic_frame_cnt: got fc %0d busy %b expected 1 0", fc_a, busy_a); end
        @(negedge aclk);
        tests++; if (ax_a.tvalid !== 1'b0) begin fails++; $display("FAIL basic_gap: got tvalid %b expected 0", ax_a.tvalid); end
        @(negedge aclk);
        tests++; if (ax_a.tvalid !== 1'b1 || ax_a.tuser !== 1'b1 || ax_a.tdata !== 48'd1) begin fails++; $display("FAIL frameid_first: got v %b u %b d %0h expected 1 1 1", ax_a.tvalid, ax_a.tuser, ax_a.tdata); end
        en_a = 1'b0;
        beat = 1; cyc = 0;
        while (beat < 12 && cyc < 100) begin
            @(negedge aclk); cyc++;
            if (ax_a.tvalid === 1'b1) begin
                tests++; if (ax_a.tdata !== 48'd1 || ax_a.tlast !== ((beat % 4) == 3)) begin fails++; $display("FAIL frameid_beat %0d: got d %0h l %b expected 1", beat, ax_a.tdata, ax_a.tlast); end
                beat++;
            end
        end
        tests++; if (beat != 12) begin fails++; $display("FAIL enable_drop_truncated: got %0d beats expected 12", beat); end
        vcnt = 0;
        repeat (20) begin @(negedge aclk); if (ax_a.tvalid === 1'b1) vcnt++; end
        tests++; if (vcnt != 0 || fc_a !== 32'd2) begin fails++; $display("FAIL enable_drop_idle: got valids %0d fc %0d expected 0 2", vcnt, fc_a); end
    endtask

    task automatic test_degenerate();
        int beat, cyc, c0;
        cfg_width = 16'd0; cfg_height = 16'd0; cfg_pattern = 2'd0; en_a = 1'b1;
        beat = 0; cyc = 0; c0 = 0;
        while (beat < 2 && cyc < 50) begin
            @(negedge aclk); cyc++;
            if (ax_a.tvalid === 1'b1) begin
                tests++; if (ax_a.tuser !== 1'b1 || ax_a.tlast !== 1'b1 || ax_a.tdata !== 48'd0) begin fails++; $display("FAIL zero_geom beat %0d: got u %b l %b d %0h expected 1 1 0", beat, ax_a.tuser, ax_a.tlast, ax_a.tdata); end
                if (beat == 1) begin
                    en_a = 1'b0;
                    tests++; if (cyc - c0 != 4) begin fails++; $display("FAIL zero_geom_gap: got %0d expected 4", cyc - c0); end
                end
                c0 = cyc;
                beat++;
            end
        end
        tests++; if (beat != 2) begin fails++; $display("FAIL zero_geom_beats: got %0d expected 2", beat); end
        repeat (5) @(negedge aclk);
        tests++; if (fc_a !== 32'd4) begin fails++; $display("FAIL zero_geom_frame_cnt: got %0d expected 4", fc_a); end
    endtask

    task automatic test_checker();
        int beat, cyc, x, y;
        logic [47:0] exp;
        cfg_width = 16'd16; cfg_height = 16'd10; cfg_pattern = 2'd2; en_a = 1'b1;
        beat = 0; cyc = 0;
        while (beat < 160 && cyc < 400) begin
            @(negedge aclk); cyc++;
            if (ax_a.tvalid === 1'b1) begin
                en_a = 1'b0;
                x = beat % 16; y = beat / 16;
                exp = ((x >= 8) != (y >= 8)) ? {48{1'b1}} : 48'd0;
                tests++; if (ax_a.tdata !== exp) begin fails++; $display("FAIL checker x %0d y %0d: got %h expected %h", x, y, ax_a.tdata, exp); end
                beat++;
            end
        end
        tests++; if (beat != 160) begin fails++; $display("FAIL checker_beats: got %0d expected 160", beat); end
        repeat (5) @(negedge aclk);
    endtask

    task automatic test_backpressure();
        int beat, cyc;
        logic pv, pr, pl, pu;
        logic [47:0] pd;
        cfg_width = 16'd8; cfg_height = 16'd1; cfg_pattern = 2'd0; en_a = 1'b1; rdy_a = 1'b0;
        beat = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pu = 1'b0; pd = 48'd0;
        while (beat < 8 && cyc < 400) begin
            @(negedge aclk); cyc++;
            if (pv && !pr) begin
                tests++; if (ax_a.tvalid !== 1'b1 || ax_a.tdata !== pd || ax_a.tlast !== pl || ax_a.tuser !== pu) begin fails++; $display("FAIL bp_stable: got v %b d %0h l %b u %b expected 1 %0h %b %b", ax_a.tvalid, ax_a.tdata, ax_a.tlast, ax_a.tuser, pd, pl, pu); end
            end
            rdy_a = ($urandom_range(0, 2) != 0) && (cyc % 5 != 0);
            if (ax_a.tvalid === 1'b1 && rdy_a) begin
                tests++; if (ax_a.tdata !== 48'(beat) || ax_a.tlast !== (beat == 7) || ax_a.tuser !== (beat == 0)) begin fails++; $display("FAIL bp_beat %0d: got d %0h l %b u %b", beat, ax_a.tdata, ax_a.tlast, ax_a.tuser); end
                beat++;
                en_a = 1'b0;
            end
            pv = ax_a.tvalid; pr = rdy_a; pd = ax_a.tdata; pl = ax_a.tlast; pu = ax_a.tuser;
        end
        tests++; if (beat != 8) begin fails++; $display("FAIL bp_beats: got %0d expected 8", beat); end
        rdy_a = 1'b1;
        repeat (6) @(negedge aclk);
    endtask

    task automatic test_pacing();
        int beats;
        rst_a = 1'b0; en_a = 1'b0;
        cfg_width = 16'd2; cfg_height = 16'd2; cfg_fps = 8'd10; cfg_pattern = 2'd0;
        repeat (2) @(negedge aclk);
        rst_a = 1'b1; en_a = 1'b1; beats = 0;
        repeat (1010) begin @(negedge aclk); if (ax_a.tvalid === 1'b1 && rdy_a) beats++; end
        en_a = 1'b0;
        tests++; if (fc_a !== 32'd10) begin fails++; $display("FAIL pacing_frames: got %0d expected 10", fc_a); end
        tests++; if (ov_a !== 16'd0) begin fails++; $display("FAIL pacing_overrun: got %0d expected 0", ov_a); end
        tests++; if (beats != 40) begin fails++; $display("FAIL pacing_beats: got %0d expected 40", beats); end
    endtask

    task automatic test_overrun();
        int beat, cyc, first_cyc, last_cyc;
        logic [15:0] ov0, ov1;
        cfg_width = 16'd16; cfg_height = 16'd16; cfg_fps = 8'd50; cfg_pattern = 2'd1;
        en_b = 1'b0; rdy_b = 1'b1; rst_b = 1'b1;
        repeat (20) @(negedge aclk);
        tests++; if (ov_b !== 16'd9) begin fails++; $display("FAIL overrun_idle: got %0d expected 9", ov_b); end
        tests++; if (ax_b.tvalid !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL overrun_idle_state: got v %b busy %b expected 0 0", ax_b.tvalid, busy_b); end
        en_b = 1'b1;
        beat = 0; cyc = 0; first_cyc = 0; last_cyc = 0; ov0 = 16'd0; ov1 = 16'd0;
        while (beat < 256 && cyc < 800) begin
            @(negedge aclk); cyc++;
            if (ax_b.tvalid === 1'b1) begin
                en_b = 1'b0;
                tests++; if (ax_b.tdata !== 48'(beat / 16) || ax_b.tlast !== ((beat % 16) == 15) || ax_b.tuser !== (beat == 0)) begin fails++; $display("FAIL yramp beat %0d: got d %0h l %b u %b", beat, ax_b.tdata, ax_b.tlast, ax_b.tuser); end
                if (beat == 0) first_cyc = cyc;
                if (beat == 50) ov0 = ov_b;
                if (beat == 150) ov1 = ov_b;
                last_cyc = cyc;
                beat++;
            end
        end
        tests++; if (beat != 256 || last_cyc - first_cyc != 255) begin fails++; $display("FAIL overrun_frame: got %0d beats span %0d expected 256 255", beat, last_cyc - first_cyc); end
        tests++; if (ov1 - ov0 != 16'd50) begin fails++; $display("FAIL overrun_rate: got %0d expected 50", ov1 - ov0); end
        repeat (3) @(negedge aclk);
        tests++; if (fc_b !== 32'd1 || ax_b.tvalid !== 1'b0) begin fails++; $display("FAIL overrun_done: got fc %0d v %b expected 1 0", fc_b, ax_b.tvalid); end
    endtask

    task automatic test_reset_mid();
        int beat, cyc;
        logic hit;
        cfg_width = 16'd4; cfg_height = 16'd4; cfg_fps = 8'd0; cfg_pattern = 2'd0; en_a = 1'b1;
        beat = 0; cyc = 0; hit = 1'b0;
        while (!hit && cyc < 100) begin
            @(negedge aclk); cyc++;
            if (ax_a.tvalid === 1'b1) begin
                if (beat == 5) hit = 1'b1;
                else beat++;
            end
        end
        tests++; if (!hit || ax_a.tdata !== 48'd1) begin fails++; $display("FAIL rst_mid_reach: got hit %b d %0h expected 1 1", hit, ax_a.tdata); end
        rst_a = 1'b0;
        @(negedge aclk);
        tests++; if (ax_a.tvalid !== 1'b0 || fc_a !== 32'd0 || busy_a !== 1'b0) begin fails++; $display("FAIL rst_mid_drop: got v %b fc %0d busy %b expected 0 0 0", ax_a.tvalid, fc_a, busy_a); end
        rst_a = 1'b1; hit = 1'b0; cyc = 0;
        while (!hit && cyc < 20) begin
            @(negedge aclk); cyc++;
            if (ax_a.tvalid === 1'b1) hit = 1'b1;
        end
        en_a = 1'b0;
        tests++; if (!hit || ax_a.tuser !== 1'b1 || ax_a.tdata !== 48'd0 || fc_a !== 32'd0) begin fails++; $display("FAIL rst_mid_restart: got hit %b u %b d %0h fc %0d expected 1 1 0 0", hit, ax_a.tuser, ax_a.tdata, fc_a); end
        repeat (25) @(negedge aclk);
    endtask

`ifdef AXIS_PATGEN_HBLANK_EN
    task automatic test_hblank();
        int beat, cyc;
        int at [6];
        cfg_hblank = 16'd3; cfg_width = 16'd2; cfg_height = 16'd3; cfg_fps = 8'd0; cfg_pattern = 2'd0;
        en_a = 1'b1; beat = 0; cyc = 0;
        while (beat < 6 && cyc < 100) begin
            @(negedge aclk); cyc++;
            if (ax_a.tvalid === 1'b1) begin
                en_a = 1'b0;
                at[beat] = cyc;
                tests++; if (ax_a.tlast !== ((beat % 2) == 1)) begin fails++; $display("FAIL hblank_tlast beat %0d: got %b", beat, ax_a.tlast); end
                beat++;
            end
        end
        tests++; if (beat != 6) begin fails++; $display("FAIL hblank_beats: got %0d expected 6", beat); end
        for (int i = 1; i < 6; i++) begin
            tests++; if (at[i] - at[i-1] != (((i % 2) == 0) ? 4 : 1)) begin fails++; $display("FAIL hblank_gap before beat %0d: got %0d expected %0d", i, at[i] - at[i-1], ((i % 2) == 0) ? 4 : 1); end
        end
        cfg_hblank = 16'd0;
        repeat (6) @(negedge aclk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_degenerate();
        test_checker();
        test_backpressure();
        test_pacing();
        test_overrun();
        test_reset_mid();
`ifdef AXIS_PATGEN_HBLANK_EN
        test_hblank();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
